countdown_timer_ctrl: RTL and testbench
=======================================

Name: countdown_timer_ctrl

Overview:
Run-control sequencer for a 4-digit MM:SS countdown, built from cascaded counter stages driven by a shared tick-enable.
- A prescaler divides CLK into a one-cycle tick.
- An FSM (IDLE/RUN/PAUSE/DONE) gates the tick into a BCD borrow chain.
- It also sequences load, start, stop and clear from single-cycle command pulses.
- Sits between the debounced button logic and the 7-segment display multiplexer.

Parameters:
- TICK_DIV, 100000000, CLK cycles per countdown step (>=2).
- DIV_WIDTH, 27, prescaler width; must hold TICK_DIV-1.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- LOAD  in  1  one-cycle pulse: load PRESET.
- START  in  1  one-cycle pulse: start or resume.
- STOP  in  1  one-cycle pulse: pause.
- CLEAR  in  1  one-cycle pulse: abort to IDLE, zero digits.
- PRESET  in  16  BCD {min_tens, min_units, sec_tens, sec_units}.
- DIGITS  out  16  current BCD value, same nibble order.
- STATE  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE.
- TICK  out  1  registered pulse, high the cycle DIGITS shows a new decremented value.
- DONE_PULSE  out  1  registered pulse, high for exactly one cycle on entry to DONE.

Behaviour:
- Reset (RESET_N low, async): STATE=IDLE, DIGITS=0, prescaler=0, TICK=0, DONE_PULSE=0.
- All other updates occur on the rising CLK edge.
- Command priority when several are high: CLEAR > LOAD > START > STOP. Only the highest-priority command acts.
- CLEAR (any state): go to IDLE, DIGITS=0, prescaler=0.
- LOAD (IDLE, PAUSE or DONE): go to IDLE, DIGITS=PRESET, prescaler=0. Ignored in RUN.
- LOAD clamps each nibble to its stage max:
  - sec_units and min_units: max 9.
  - sec_tens and min_tens: max 5.
  - Example: PRESET 16'h7A9F loads as 16'h5959.
- START in IDLE:
  - DIGITS != 0: go to RUN, prescaler=0.
  - DIGITS == 0: ignored.
- START in PAUSE: go to RUN, prescaler keeps its held value.
- START in RUN or DONE: ignored.
- STOP in RUN: go to PAUSE, prescaler holds. Ignored elsewhere.
- Prescaler:
  - Counts only in RUN; wraps at TICK_DIV-1 back to 0.
  - On the wrap edge, DIGITS decrements by 1 s and TICK=1 in the following cycle.
  - First TICK arrives exactly TICK_DIV cycles after the START edge from IDLE.
- Decrement chain:
  - sec_units 0 -> 9 with borrow.
  - sec_tens 0 -> 5 with borrow.
  - min_units 0 -> 9 with borrow.
  - min_tens decrements by 1.
  - Never decrements from 0000, since RUN is never entered at zero.
- Decrement reaching 0000: on the same edge STATE=DONE, DONE_PULSE=1 for one cycle, TICK=1 for that cycle, prescaler=0.
- STOP on the wrap edge: decrement still applies and the state becomes PAUSE. If that decrement reaches 0000, DONE wins over PAUSE.
- CLEAR or LOAD on the wrap edge: the command wins; no decrement, TICK=0, DONE_PULSE=0.
- DONE holds DIGITS=0000 until CLEAR or LOAD.
- RESET_N asserted mid-count: immediate return to reset values. No state is retained.
- STATE, TICK and DONE_PULSE are registers, not decoded combinationally.

Decomposition:
- Shared package (timer_pkg):
  - State encoding constants ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE.
  - Digit max constants SEC_UNITS_MAX=9, SEC_TENS_MAX=5.
  - Shared with display and test bench.
- One sub-module, bcd_down_stage:
  - Parameter MAX.
  - Inputs: load, load value, dec enable, async reset.
  - Outputs: 4-bit digit, borrow_out (digit==0 && dec).
- Four bcd_down_stage instances are chained by borrow. The prescaler and FSM live in the top module.

Test Plan:
- Reset/idle: RESET_N low mid-RUN with DIGITS=0012 -> STATE=00, DIGITS=0000, TICK=0, DONE_PULSE=0 immediately (before next CLK edge).
- Basic countdown (TICK_DIV=4): LOAD PRESET=0003, START -> TICK at cycles 4, 8, 12 after START; DIGITS 0002, 0001, 0000; STATE=11 and DONE_PULSE=1 only at cycle 12.
- Borrow chain (TICK_DIV=4): LOAD 1000, START -> after first TICK DIGITS=0959; LOAD 16'h7A9F -> DIGITS=5959.
- Pause/resume (TICK_DIV=4): START with DIGITS=0005, STOP 2 cycles later -> STATE=10, no TICK for 20 cycles; START -> next TICK exactly 2 cycles later, DIGITS=0004.
- Simultaneity: LOAD+START+STOP same cycle in IDLE -> only the load takes effect, STATE stays 00. CLEAR on the wrap edge -> DIGITS=0000, TICK=0. STOP on the wrap edge with DIGITS=0001 -> STATE=11, DONE_PULSE=1.
- Ignored commands: START with DIGITS=0000 -> STATE stays 00. LOAD in RUN -> DIGITS unchanged. START in DONE -> STATE stays 11.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared encodings and digit limits for the MM:SS countdown timer.
// Also used by the display multiplexer and the test bench.
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_e;

   localparam int unsigned SEC_UNITS_MAX = 9;
   localparam int unsigned SEC_TENS_MAX  = 5;
   localparam int unsigned MIN_UNITS_MAX = 9;
   localparam int unsigned MIN_TENS_MAX  = 5;

   function automatic logic [3:0] clamp_digit(input logic [3:0] val, input logic [3:0] max);
      return (val > max) ? max : val;
   endfunction

endpackage

// File: rtl/bcd_down_stage.sv
// One BCD down-counter digit: loads a clamped value, decrements on dec,
// and wraps 0 -> MAX with a borrow to the next stage.
module bcd_down_stage
   import timer_pkg::*;
#(
   parameter int unsigned MAX = 9
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic [3:0] digit,
   output logic       borrow_out
);

   localparam logic [3:0] MAX_DIGIT = 4'(MAX);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         digit <= 4'd0;
      end else if (load) begin
         digit <= clamp_digit(load_val, MAX_DIGIT);
      end else if (dec) begin
         digit <= (digit == 4'd0) ? MAX_DIGIT : digit - 4'd1;
      end
   end

   assign borrow_out = (digit == 4'd0) && dec;

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Run-control sequencer for a 4-digit MM:SS countdown: prescaler, IDLE/RUN/PAUSE/DONE
// FSM and a borrow-chained BCD digit counter.
module countdown_timer_ctrl
   import timer_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 100000000,
   parameter int unsigned DIV_WIDTH = 27
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        LOAD,
   input  logic        START,
   input  logic        STOP,
   input  logic        CLEAR,
   input  logic [15:0] PRESET,
   output logic [15:0] DIGITS,
   output logic [1:0]  STATE,
   output logic        TICK,
   output logic        DONE_PULSE
);

   localparam logic [DIV_WIDTH-1:0] WRAP_VAL = DIV_WIDTH'(TICK_DIV - 1);

   state_e               state_q, state_d;
   logic [DIV_WIDTH-1:0] presc_q, presc_d;
   logic                 tick_q, tick_d;
   logic                 done_q, done_d;
   logic                 load_en;
   logic [15:0]          load_val;
   logic                 dec_en;
   logic [3:0]           borrow;
   logic                 wrap;

   assign wrap = (state_q == ST_RUN) && (presc_q == WRAP_VAL);

   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      tick_d   = 1'b0;
      done_d   = 1'b0;
      load_en  = 1'b0;
      load_val = PRESET;
      dec_en   = 1'b0;

      if (CLEAR) begin
         state_d  = ST_IDLE;
         presc_d  = '0;
         load_en  = 1'b1;
         load_val = 16'h0000;
      end else if (LOAD && (state_q != ST_RUN)) begin
         state_d = ST_IDLE;
         presc_d = '0;
         load_en = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (START && (DIGITS != 16'h0000)) begin
                  state_d = ST_RUN;
                  presc_d = '0;
               end
            end
            ST_PAUSE: begin
               if (START) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (wrap) begin
                  dec_en  = 1'b1;
                  tick_d  = 1'b1;
                  presc_d = '0;
                  // Reaching 0000 takes precedence over a simultaneous STOP.
                  if (DIGITS == 16'h0001) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else if (STOP) begin
                     state_d = ST_PAUSE;
                  end
               end else begin
                  presc_d = presc_q + DIV_WIDTH'(1);
                  if (STOP) state_d = ST_PAUSE;
               end
            end
            ST_DONE: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         presc_q <= '0;
         tick_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         tick_q  <= tick_d;
         done_q  <= done_d;
      end
   end

   bcd_down_stage #(.MAX(SEC_UNITS_MAX)) u_sec_units (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .load       (load_en),
      .load_val   (load_val[3:0]),
      .dec        (dec_en),
      .digit      (DIGITS[3:0]),
      .borrow_out (borrow[0])
   );

   bcd_down_stage #(.MAX(SEC_TENS_MAX)) u_sec_tens (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .load       (load_en),
      .load_val   (load_val[7:4]),
      .dec        (borrow[0]),
      .digit      (DIGITS[7:4]),
      .borrow_out (borrow[1])
   );

   bcd_down_stage #(.MAX(MIN_UNITS_MAX)) u_min_units (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .load       (load_en),
      .load_val   (load_val[11:8]),
      .dec        (borrow[1]),
      .digit      (DIGITS[11:8]),
      .borrow_out (borrow[2])
   );

   bcd_down_stage #(.MAX(MIN_TENS_MAX)) u_min_tens (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .load       (load_en),
      .load_val   (load_val[15:12]),
      .dec        (borrow[2]),
      .digit      (DIGITS[15:12]),
      .borrow_out (borrow[3])
   );

   // RUN is never entered at 0000, so the top stage can never borrow.
   assert property (@(posedge CLK) disable iff (!RESET_N) !borrow[3]);

   assign STATE      = state_q;
   assign TICK       = tick_q;
   assign DONE_PULSE = done_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Self-checking bench for countdown_timer_ctrl with TICK_DIV=4: per-cycle vector table
// fed through a scoreboard queue, plus reset and bounded-wait sequences.
module tb_countdown_timer_ctrl;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic        LOAD, START, STOP, CLEAR;
   logic [15:0] PRESET;
   logic [15:0] DIGITS;
   logic [1:0]  STATE;
   logic        TICK, DONE_PULSE;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   countdown_timer_ctrl #(.TICK_DIV(4), .DIV_WIDTH(3)) dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .LOAD       (LOAD),
      .START      (START),
      .STOP       (STOP),
      .CLEAR      (CLEAR),
      .PRESET     (PRESET),
      .DIGITS     (DIGITS),
      .STATE      (STATE),
      .TICK       (TICK),
      .DONE_PULSE (DONE_PULSE)
   );

   typedef struct {
      string       name;
      logic        ld, st, sp, cl;
      logic [15:0] preset;
      logic [15:0] exp_digits;
      logic [1:0]  exp_state;
      logic        exp_tick, exp_done;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input string n, input logic ld, input logic st, input logic sp,
                      input logic cl, input logic [15:0] pre, input logic [15:0] dig,
                      input logic [1:0] s, input logic t, input logic d);
      vec_t v;
      v.name = n; v.ld = ld; v.st = st; v.sp = sp; v.cl = cl; v.preset = pre;
      v.exp_digits = dig; v.exp_state = s; v.exp_tick = t; v.exp_done = d;
      tbl.push_back(v);
   endtask

   task automatic idle(input string n, input int cnt, input logic [15:0] dig, input logic [1:0] s);
      for (int k = 0; k < cnt; k++) add(n, 0, 0, 0, 0, 16'h0, dig, s, 0, 0);
   endtask

   // Drive one cycle of commands, then compare against the scoreboard head after the edge.
   task automatic apply(input vec_t v, input int idx);
      vec_t e;
      LOAD = v.ld; START = v.st; STOP = v.sp; CLEAR = v.cl; PRESET = v.preset;
      exp_q.push_back(v);
      @(posedge CLK);
      #1;
      LOAD = 0; START = 0; STOP = 0; CLEAR = 0;
      e = exp_q.pop_front();
      chk($sformatf("%s[%0d].digits", e.name, idx), 32'(DIGITS), 32'(e.exp_digits));
      chk($sformatf("%s[%0d].state", e.name, idx), 32'(STATE), 32'(e.exp_state));
      chk($sformatf("%s[%0d].tick", e.name, idx), 32'(TICK), 32'(e.exp_tick));
      chk($sformatf("%s[%0d].done", e.name, idx), 32'(DONE_PULSE), 32'(e.exp_done));
   endtask

   initial begin
      int cycles;
      vec_t v;

      // Ignored commands, clamp, simultaneous commands
      add("start_at_zero", 0, 1, 0, 0, 16'h0, 16'h0000, 2'b00, 0, 0);
      add("load_clamp",    1, 0, 0, 0, 16'h7A9F, 16'h5959, 2'b00, 0, 0);
      add("ld_st_sp",      1, 1, 1, 0, 16'h0003, 16'h0003, 2'b00, 0, 0);
      // Basic countdown from 0003
      add("start",         0, 1, 0, 0, 16'h0, 16'h0003, 2'b01, 0, 0);
      idle("run3", 3, 16'h0003, 2'b01);
      add("tick1",         0, 0, 0, 0, 16'h0, 16'h0002, 2'b01, 1, 0);
      idle("run2", 3, 16'h0002, 2'b01);
      add("tick2",         0, 0, 0, 0, 16'h0, 16'h0001, 2'b01, 1, 0);
      idle("run1", 3, 16'h0001, 2'b01);
      add("tick3_done",    0, 0, 0, 0, 16'h0, 16'h0000, 2'b11, 1, 1);
      idle("done_hold", 1, 16'h0000, 2'b11);
      add("start_in_done", 0, 1, 0, 0, 16'h0, 16'h0000, 2'b11, 0, 0);
      // Borrow through all stages, LOAD ignored in RUN
      add("load1000",      1, 0, 0, 0, 16'h1000, 16'h1000, 2'b00, 0, 0);
      add("start1000",     0, 1, 0, 0, 16'h0, 16'h1000, 2'b01, 0, 0);
      idle("run1000", 3, 16'h1000, 2'b01);
      add("borrow",        0, 0, 0, 0, 16'h0, 16'h0959, 2'b01, 1, 0);
      add("load_in_run",   1, 0, 0, 0, 16'h0042, 16'h0959, 2'b01, 0, 0);
      add("clear_run",     0, 0, 0, 1, 16'h0, 16'h0000, 2'b00, 0, 0);
      // Pause and resume keeps the prescaler phase
      add("load5",         1, 0, 0, 0, 16'h0005, 16'h0005, 2'b00, 0, 0);
      add("start5",        0, 1, 0, 0, 16'h0, 16'h0005, 2'b01, 0, 0);
      idle("run5", 1, 16'h0005, 2'b01);
      add("stop",          0, 0, 1, 0, 16'h0, 16'h0005, 2'b10, 0, 0);
      idle("paused", 20, 16'h0005, 2'b10);
      add("resume",        0, 1, 0, 0, 16'h0, 16'h0005, 2'b01, 0, 0);
      idle("resumed", 1, 16'h0005, 2'b01);
      add("resume_tick",   0, 0, 0, 0, 16'h0, 16'h0004, 2'b01, 1, 0);
      // CLEAR on the wrap edge beats the decrement
      idle("run4", 3, 16'h0004, 2'b01);
      add("clear_wrap",    0, 0, 0, 1, 16'h0, 16'h0000, 2'b00, 0, 0);
      // STOP on a wrap edge that reaches zero: DONE wins
      add("load1",         1, 0, 0, 0, 16'h0001, 16'h0001, 2'b00, 0, 0);
      add("start1",        0, 1, 0, 0, 16'h0, 16'h0001, 2'b01, 0, 0);
      idle("run_one", 3, 16'h0001, 2'b01);
      add("stop_wrap_done",0, 0, 1, 0, 16'h0, 16'h0000, 2'b11, 1, 1);
      idle("done_after", 1, 16'h0000, 2'b11);
      // STOP on a non-final wrap edge: decrement applies, then PAUSE
      add("load2",         1, 0, 0, 0, 16'h0002, 16'h0002, 2'b00, 0, 0);
      add("start2",        0, 1, 0, 0, 16'h0, 16'h0002, 2'b01, 0, 0);
      idle("run_two", 3, 16'h0002, 2'b01);
      add("stop_wrap",     0, 0, 1, 0, 16'h0, 16'h0001, 2'b10, 1, 0);
      add("resume0",       0, 1, 0, 0, 16'h0, 16'h0001, 2'b01, 0, 0);
      idle("run_last", 3, 16'h0001, 2'b01);
      add("final_tick",    0, 0, 0, 0, 16'h0, 16'h0000, 2'b11, 1, 1);

      RESET_N = 1'b0;
      LOAD = 0; START = 0; STOP = 0; CLEAR = 0; PRESET = 16'h0;
      #12;
      chk("reset.digits", 32'(DIGITS), 32'h0);
      chk("reset.state", 32'(STATE), 32'h0);
      chk("reset.tick", 32'(TICK), 32'h0);
      chk("reset.done", 32'(DONE_PULSE), 32'h0);
      RESET_N = 1'b1;

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

      // Asynchronous reset mid-RUN with DIGITS=0012
      v.name = "rst_seq"; v.ld = 1; v.st = 0; v.sp = 0; v.cl = 0; v.preset = 16'h0012;
      v.exp_digits = 16'h0012; v.exp_state = 2'b00; v.exp_tick = 0; v.exp_done = 0;
      apply(v, 0);
      v.ld = 0; v.st = 1; v.exp_state = 2'b01;
      apply(v, 1);
      v.st = 0;
      apply(v, 2);
      #3;
      RESET_N = 1'b0;
      #1;
      chk("async_rst.digits", 32'(DIGITS), 32'h0);
      chk("async_rst.state", 32'(STATE), 32'h0);
      chk("async_rst.tick", 32'(TICK), 32'h0);
      chk("async_rst.done", 32'(DONE_PULSE), 32'h0);
      @(posedge CLK);
      #1;
      RESET_N = 1'b1;
      chk("rst_hold.state", 32'(STATE), 32'h0);

      // Bounded wait for DONE_PULSE: 0003 needs 12 cycles after START
      v.name = "wait_seq"; v.ld = 1; v.st = 0; v.preset = 16'h0003;
      v.exp_digits = 16'h0003; v.exp_state = 2'b00;
      apply(v, 0);
      v.ld = 0; v.st = 1; v.exp_state = 2'b01;
      apply(v, 1);
      cycles = 0;
      while (cycles < 40) begin
         @(posedge CLK);
         #1;
         cycles++;
         if (DONE_PULSE === 1'b1) break;
      end
      chk("done_latency", 32'(cycles), 32'd12);
      chk("done_state", 32'(STATE), 32'h3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
